// File: rtl/present_pkg.sv
// present_pkg: PRESENT-80 widths, S-box table and key-schedule state encoding.
package present_pkg;
  localparam int KEY_W = 80;
  localparam int RK_W = 64;
  localparam int NROUNDS = 31;
  localparam logic [5:0] LAST_ROUND = 6'(NROUNDS + 1);
  localparam logic [3:0] SBOX [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                       4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
  typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/present_sbox4.sv
// present_sbox4: 4-bit PRESENT S-box lookup, shared with the round datapath.
module present_sbox4 import present_pkg::*; (
  input  logic [3:0] x,
  output logic [3:0] y
);
  assign y = SBOX[x];
endmodule

// File: rtl/present_key_schedule.sv
// present_key_schedule: streams PRESENT-80 round keys K1..K32 over valid/ready.
module present_key_schedule import present_pkg::*; (
  input  logic             clk,
  input  logic             reset,
  input  logic [KEY_W-1:0] key,
  input  logic             key_valid,
  output logic             key_ready,
  output logic [RK_W-1:0]  round_key,
  output logic [5:0]       round_num,
  output logic             rk_valid,
  output logic             rk_last,
  input  logic             rk_ready
);
  state_t state, state_nxt;
  logic [KEY_W-1:0] key_reg, key_nxt, rot;
  logic [5:0] cnt, cnt_nxt;
  logic [3:0] sb_out;
  assign rot = {key_reg[18:0], key_reg[79:19]};
  present_sbox4 u_sbox (.x(rot[79:76]), .y(sb_out));
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      key_reg <= '0;
      cnt <= '0;
    end else begin
      state <= state_nxt;
      key_reg <= key_nxt;
      cnt <= cnt_nxt;
    end
  end
  always_comb begin
    state_nxt = state;
    key_nxt = key_reg;
    cnt_nxt = cnt;
    if (state == IDLE && key_valid) begin
      state_nxt = RUN;
      key_nxt = key;
      cnt_nxt = 6'd1;
    end else if (state == RUN && rk_ready) begin
      if (cnt == LAST_ROUND) state_nxt = IDLE;
      else begin
        key_nxt = {sb_out, rot[75:20], rot[19:15] ^ cnt[4:0], rot[14:0]};
        cnt_nxt = cnt + 6'd1;
      end
    end
  end
  // after a finished schedule the last key stays visible with rk_valid low
  assign key_ready = state == IDLE;
  assign rk_valid = state == RUN;
  assign rk_last = rk_valid && cnt == LAST_ROUND;
  assign round_key = key_reg[KEY_W-1:KEY_W-RK_W];
  assign round_num = cnt;
endmodule

// File: tb/tb_present_key_schedule.sv
// tb_present_key_schedule: directed + randomized checks against a behavioural PRESENT-80 model.
module tb_present_key_schedule;
  logic clk = 0, reset = 0, key_valid = 0, rk_ready = 0;
  logic [79:0] key = '0;
  logic key_ready, rk_valid, rk_last;
  logic [63:0] round_key;
  logic [5:0] round_num;
  int errors = 0, checks = 0;
  int sb [16] = '{'hC, 5, 6, 'hB, 9, 0, 'hA, 'hD, 3, 'hE, 'hF, 8, 4, 7, 1, 2};
  logic [63:0] got [1:32];

  present_key_schedule dut (
    .clk(clk), .reset(reset), .key(key), .key_valid(key_valid), .key_ready(key_ready),
    .round_key(round_key), .round_num(round_num), .rk_valid(rk_valid), .rk_last(rk_last),
    .rk_ready(rk_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [79:0] next_key(input logic [79:0] k, input int r);
    logic [79:0] t;
    t = (k << 61) | (k >> 19);
    t[79:76] = 4'(sb[t[79:76]]);
    return t ^ (80'(r[4:0]) << 15);
  endfunction

  function automatic logic [63:0] encrypt(input logic [63:0] p);
    logic [63:0] s, o;
    s = p;
    for (int r = 1; r <= 31; r++) begin
      s ^= got[r];
      for (int n = 0; n < 16; n++) s[4*n +: 4] = 4'(sb[s[4*n +: 4]]);
      o = '0;
      for (int i = 0; i < 63; i++) o[(16 * i) % 63] = s[i];
      o[63] = s[63];
      s = o;
    end
    return s ^ got[32];
  endfunction

  task automatic load(input logic [79:0] k);
    int w;
    w = 0;
    while (!key_ready && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    chk("accept_wait", 80'(w), 80'(0));
    key = k;
    key_valid = 1;
    @(posedge clk); #1;
    key_valid = 0;
    chk("busy_key_ready", 80'(key_ready), 80'(0));
  endtask

  // mode 0: rk_ready held high; 1: random backpressure with a 10-cycle stall at round 7;
  // 2: as 1 while a different key is presented throughout the run
  task automatic collect(input logic [79:0] k, input int mode);
    logic [79:0] kr;
    int idx, stall, cyc;
    kr = k; idx = 1; stall = 0; cyc = 0;
    while (idx <= 32 && cyc < 1000) begin
      if (mode != 0 && idx == 7 && stall < 10) begin
        rk_ready = 0;
        stall++;
      end else rk_ready = mode == 0 ? 1'b1 : ($urandom_range(0, 2) != 0);
      if (mode == 2) begin
        key_valid = 1;
        key = ~k;
      end
      chk("rk_valid", 80'(rk_valid), 80'(1));
      chk("round_num", 80'(round_num), 80'(idx));
      chk("round_key", 80'(round_key), 80'(kr[79:16]));
      chk("rk_last", 80'(rk_last), 80'(idx == 32));
      chk("key_ready_run", 80'(key_ready), 80'(0));
      got[idx] = round_key;
      @(posedge clk); #1;
      cyc++;
      if (rk_ready) begin
        if (idx < 32) kr = next_key(kr, idx);
        idx++;
      end
    end
    chk("schedule_done", 80'(idx), 80'(33));
    key_valid = 0;
    rk_ready = 0;
    chk("done_rk_valid", 80'(rk_valid), 80'(0));
    chk("done_key_ready", 80'(key_ready), 80'(1));
    chk("done_round_key", 80'(round_key), 80'(kr[79:16]));
  endtask

  initial begin
    logic [79:0] k;
    #2;
    chk("rst_key_ready", 80'(key_ready), 80'(1));
    chk("rst_rk_valid", 80'(rk_valid), 80'(0));
    chk("rst_rk_last", 80'(rk_last), 80'(0));
    chk("rst_round_key", 80'(round_key), 80'(0));
    chk("rst_round_num", 80'(round_num), 80'(0));
    #20 reset = 1;
    @(posedge clk); #1;
    chk("idle_rk_valid", 80'(rk_valid), 80'(0));

    load(80'h0);
    collect(80'h0, 0);
    chk("zero_K1", 80'(got[1]), 80'(64'h0000000000000000));
    chk("zero_K2", 80'(got[2]), 80'(64'hc000000000000000));
    chk("zero_K3", 80'(got[3]), 80'(64'h5000180000000001));
    chk("cipher_zero", 80'(encrypt(64'h0)), 80'(64'h5579c1387b228445));

    load({80{1'b1}});
    collect({80{1'b1}}, 0);
    chk("cipher_ones", 80'(encrypt({64{1'b1}})), 80'(64'h3333dcd3213210d2));

    load(80'h0);
    collect(80'h0, 1);
    chk("stalled_cipher_zero", 80'(encrypt(64'h0)), 80'(64'h5579c1387b228445));

    for (int n = 0; n < 3; n++) begin
      k = {32'($urandom()), 32'($urandom()), 16'($urandom())};
      load(k);
      collect(k, n == 0 ? 2 : 1);
    end

    k = {32'($urandom()), 32'($urandom()), 16'($urandom())};
    load(k);
    rk_ready = 1;
    repeat (11) begin
      @(posedge clk); #1;
    end
    chk("pre_reset_round_num", 80'(round_num), 80'(12));
    reset = 0;
    #1;
    chk("async_rk_valid", 80'(rk_valid), 80'(0));
    chk("async_rk_last", 80'(rk_last), 80'(0));
    chk("async_round_key", 80'(round_key), 80'(0));
    chk("async_round_num", 80'(round_num), 80'(0));
    chk("async_key_ready", 80'(key_ready), 80'(1));
    #1 reset = 1;
    rk_ready = 0;
    @(posedge clk); #1;
    chk("post_reset_idle", 80'(rk_valid), 80'(0));
    k = {32'($urandom()), 32'($urandom()), 16'($urandom())};
    load(k);
    collect(k, 1);

    k = {32'($urandom()), 32'($urandom()), 16'($urandom())};
    load(k);
    collect(k, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
